// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor: Difference = In_A - In_B - Borrow_in.
// One full-subtractor cell is time-shared across all bit positions. It handles
// one bit per clock, LSB first. The borrow out of each bit is recirculated
// through a flip-flop into the next bit.
//
// Ports
//   clk_i       in   1      clock, rising edge
//   rst_i       in   1      synchronous active-high reset
//   start       in   1      operation request, sampled only in IDLE
//   In_A        in   WIDTH  minuend, latched on accepted start
//   In_B        in   WIDTH  subtrahend, latched on accepted start
//   Borrow_in   in   1      initial borrow into bit 0, latched on accepted start
//   busy        out  1      high while bits are being processed (RUN)
//   done        out  1      single-cycle pulse, results valid
//   Difference  out  WIDTH  last completed result
//   Borrow_out  out  1      final borrow out of the MSB (unsigned wrap)
//   Overflow    out  1      two's-complement signed overflow
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; results of the last operation are held
//   RUN     | one bit per edge through the cell, WIDTH edges in total
//   DONE    | results registers hold the new result, done pulses
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic             Borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow_out,
    output logic             Overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only WIDTH-1 result bits need storing. The final bit comes straight
    // from the cell on the last edge.
    logic [WIDTH-2:0] res_sr;
    logic             borrow_q;

    logic             cell_a;
    logic             cell_b;
    logic             cell_bin;
    logic             cell_d;
    logic             cell_bout;

    logic [WIDTH-1:0] res_full;
    logic             last_bit;
    logic             ovf_final;

    // ------------------------------------------------------------------
    // Full-subtractor cell: a - b - bin
    // ------------------------------------------------------------------
    assign cell_a   = a_sr[0];
    assign cell_b   = b_sr[0];
    assign cell_bin = borrow_q;

    always_comb begin
        cell_d    = cell_a ^ cell_b ^ cell_bin;
        cell_bout = (~cell_a & (cell_b | cell_bin)) | (cell_b & cell_bin);
    end

    // The cell output becomes the MSB of the partially assembled result.
    // On the last bit this vector is the complete difference.
    assign res_full = {cell_d, res_sr};
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    // On the last bit the operand registers have shifted their MSBs down to
    // bit 0, so the sign bits of the latched operands are still available here.
    assign ovf_final = (cell_a ^ cell_b) & (cell_d ^ cell_a);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand / result shift registers, borrow FF, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt    <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_q   <= 1'b0;
            Difference <= '0;
            Borrow_out <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr     <= In_A;
                        b_sr     <= In_B;
                        borrow_q <= Borrow_in;
                        res_sr   <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr   <= res_full[WIDTH-1:1];
                    borrow_q <= cell_bout;
                    bit_cnt  <= bit_cnt + CW'(1);
                    // Results are loaded on the edge that enters DONE.
                    // They are therefore already valid while done is high.
                    if (last_bit) begin
                        Difference <= res_full;
                        Borrow_out <= cell_bout;
                        Overflow   <= ovf_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start;
    logic [W-1:0] In_A;
    logic [W-1:0] In_B;
    logic         Borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] Difference;
    logic         Borrow_out;
    logic         Overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start      (start),
        .In_A       (In_A),
        .In_B       (In_B),
        .Borrow_in  (Borrow_in),
        .busy       (busy),
        .done       (done),
        .Difference (Difference),
        .Borrow_out (Borrow_out),
        .Overflow   (Overflow)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: integer arithmetic plus a cycle countdown
    // ------------------------------------------------------------------
    bit           m_valid = 1'b0;
    int           m_left  = 0;      // edges still to go before results appear
    bit           m_done  = 1'b0;
    logic [W-1:0] m_diff  = '0;
    bit           m_bout  = 1'b0;
    bit           m_ovf   = 1'b0;
    logic [W-1:0] p_diff;
    bit           p_bout;
    bit           p_ovf;

    always @(posedge clk_i) begin : model
        int ua, ub, ud, sa, sb, sd;
        if (rst_i) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_done  = 1'b0;
            m_diff  = '0;
            m_bout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_diff = p_diff;
                m_bout = p_bout;
                m_ovf  = p_ovf;
            end
        end else if (start) begin
            ua = int'(In_A);
            ub = int'(In_B);
            ud = ua - ub - int'(Borrow_in);
            p_diff = W'(((ud % (2 ** W)) + (2 ** W)) % (2 ** W));
            p_bout = (ud < 0);
            sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
            sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
            sd = sa - sb - int'(Borrow_in);
            p_ovf  = (sd < -(2 ** (W - 1))) || (sd > 2 ** (W - 1) - 1);
            m_left = W;
        end
    end

    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("cyc_busy", busy, (m_left > 0) ? 1 : 0);
            chk("cyc_done", done, m_done);
            chk("cyc_diff", Difference, m_diff);
            chk("cyc_bout", Borrow_out, m_bout);
            chk("cyc_ovf",  Overflow, m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        In_A = a; In_B = b; Borrow_in = bin; start = 1'b1;
        @(posedge clk_i); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk_i); #1;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_diff"}, Difference, ed);
        chk({tag, "_bout"}, Borrow_out, eb);
        chk({tag, "_ovf"}, Overflow, eo);
        @(posedge clk_i); #1;
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        int dcnt;
        int lat_at;
        rst_i = 1'b1; start = 1'b0; In_A = '0; In_B = '0; Borrow_in = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", Difference, 0);
        chk("rst_bout", Borrow_out, 0);
        chk("rst_ovf",  Overflow, 0);

        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "t35_12");
        chk("model_pin_23", m_diff, 8'h23);
        run_op(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, "t12_35");
        chk("model_pin_dd", {m_bout, m_diff}, 9'h1DD);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t80_01");
        chk("model_pin_ovf", m_ovf, 1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "t00_00_b");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "t7f_ff");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "tff_ff_b");
        run_op(8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, "t00_80");

        // start during RUN is ignored, prior result held until done
        In_A = 8'h35; In_B = 8'h12; Borrow_in = 1'b0; start = 1'b1;
        @(posedge clk_i); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        start = 1'b1; In_A = 8'hFF; In_B = 8'h00; Borrow_in = 1'b1;
        chk("ign_held_diff", Difference, 8'h80);
        chk("ign_busy", busy, 1);
        @(posedge clk_i); #1;
        start = 1'b0;
        In_A = 8'hA5;
        dcnt = 0;
        lat_at = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk_i); #1;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    lat_at = i + 3;
                    chk("ign_diff", Difference, 8'h23);
                    chk("ign_bout", Borrow_out, 0);
                    chk("ign_ovf",  Overflow, 0);
                end
            end
        end
        chk("ign_done_count", dcnt, 1);
        chk("ign_latency", lat_at, 8);

        // reset on cycle 4 of RUN abandons the operation
        In_A = 8'h35; In_B = 8'h12; Borrow_in = 1'b0; start = 1'b1;
        @(posedge clk_i); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        chk("mid_busy_before_rst", busy, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_diff", Difference, 0);
        chk("mid_rst_bout", Borrow_out, 0);
        chk("mid_rst_ovf",  Overflow, 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (done) dcnt++;
        end
        chk("mid_rst_no_done", dcnt, 0);
        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
